// File: rtl/reg_spi_sequencer_pkg.sv
// Shared definitions for the register SPI sequencer: FSM states, renderer command codes,
// and the payload-length clamp helper.
package reg_spi_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWaitVs = 3'd1,
        StSetup  = 3'd2,
        StShift  = 3'd3,
        StHold   = 3'd4,
        StGap    = 3'd5
    } seq_state_e;

    // Renderer register map, for request sources and benches.
    localparam logic [3:0] REG_CMD_SKY     = 4'h0;
    localparam logic [3:0] REG_CMD_FLOOR   = 4'h1;
    localparam logic [3:0] REG_CMD_LEAK    = 4'h2;
    localparam logic [3:0] REG_CMD_OTHER   = 4'h3;
    localparam logic [3:0] REG_CMD_VECTORS = 4'h4;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: pulses o_tick every CLK_DIV cycles while enabled and
// restarts from zero whenever it is disabled.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));
    assign o_tick = i_en && w_wrap;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!i_en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reg_spi_sequencer.sv
// Serialises {cmd, payload} register writes onto the renderer's mode-0 register SPI port.
// Optional frame-boundary gating on i_vsync with `REG_SPI_SEQ_VSYNC_GATE_EN.
module reg_spi_sequencer
    import reg_spi_sequencer_pkg::*;
#(
    parameter int unsigned CMD_W   = 4,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAP_CYC = 2,
    localparam int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_csb,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_busy,
    output logic              o_done
`ifdef REG_SPI_SEQ_VSYNC_GATE_EN
    ,
    input  logic              i_vsync
`endif
);

    localparam int unsigned SH_W  = CMD_W + DATA_W;
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    seq_state_e        r_state, w_state_next;
    logic [SH_W-1:0]   r_shreg, w_shreg_next;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic [CNT_W-1:0]  r_n_bits, w_n_bits_next;
    logic              r_sclk, w_sclk_next;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_next;

    logic              w_tick;
    logic              w_frame;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_shamt;
    logic [DATA_W-1:0] w_payload;

    // Out-of-range lengths clamp to a full payload; the shift left-aligns the sent bits.
    assign w_len     = LEN_W'(clamp_len(32'(i_len), DATA_W));
    assign w_shamt   = LEN_W'(DATA_W) - w_len;
    assign w_payload = i_data << w_shamt;

`ifdef REG_SPI_SEQ_VSYNC_GATE_EN
    logic r_vsync_prev;
    logic w_vsync_rise;

    assign w_vsync_rise = i_vsync && !r_vsync_prev;

    // Resets high so a vsync already high at reset release is not taken as an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vsync_prev <= 1'b1;
        end else begin
            r_vsync_prev <= i_vsync;
        end
    end
`endif

    assign w_frame = (r_state == StSetup) || (r_state == StShift) || (r_state == StHold);

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_frame),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_bit_cnt_next = r_bit_cnt;
        w_n_bits_next  = r_n_bits;
        w_sclk_next    = r_sclk;
        w_gap_cnt_next = r_gap_cnt;

        unique case (r_state)
            StIdle: begin
                if (i_valid) begin
                    w_shreg_next   = {i_cmd, w_payload};
                    w_n_bits_next  = CNT_W'(CMD_W) + CNT_W'(w_len);
                    w_bit_cnt_next = '0;
                    w_sclk_next    = 1'b0;
`ifdef REG_SPI_SEQ_VSYNC_GATE_EN
                    w_state_next   = StWaitVs;
`else
                    w_state_next   = StSetup;
`endif
                end
            end
`ifdef REG_SPI_SEQ_VSYNC_GATE_EN
            StWaitVs: begin
                if (w_vsync_rise) begin
                    w_state_next = StSetup;
                end
            end
`endif
            StSetup: begin
                if (w_tick) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (w_tick) begin
                    w_sclk_next = !r_sclk;
                    // Falling edge: advance to the next bit while SCLK is low.
                    if (r_sclk) begin
                        w_shreg_next   = r_shreg << 1;
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                        if ((r_bit_cnt + CNT_W'(1)) == r_n_bits) begin
                            w_state_next = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (w_tick) begin
                    w_gap_cnt_next = '0;
                    w_state_next   = StGap;
                end
            end
            StGap: begin
                if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    w_state_next = StIdle;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_n_bits  <= '0;
            r_sclk    <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_shreg   <= w_shreg_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_n_bits  <= w_n_bits_next;
            r_sclk    <= w_sclk_next;
            r_gap_cnt <= w_gap_cnt_next;
        end
    end

    // Outputs decode straight from registers so an async reset clears them at once.
    assign o_ready = (r_state == StIdle);
    assign o_busy  = !o_ready;
    assign o_csb   = !w_frame;
    assign o_sclk  = r_sclk;
    assign o_mosi  = w_frame && r_shreg[SH_W-1];
    assign o_done  = (r_state == StGap) && (r_gap_cnt == '0);

endmodule

// File: tb/tb_reg_spi_sequencer.sv
// Scoreboard bench for reg_spi_sequencer: stimulus queues expected frames, a monitor
// decodes the SPI lines and compares each completed frame.
module tb_reg_spi_sequencer;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned GAP_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  cmd = '0;
    logic [23:0] data = '0;
    logic [4:0]  len = '0;
    logic        o_ready, o_csb, o_sclk, o_mosi, o_busy, o_done;
`ifdef REG_SPI_SEQ_VSYNC_GATE_EN
    logic        vsync = 1'b1;
`endif

    reg_spi_sequencer #(
        .CMD_W   (4),
        .DATA_W  (24),
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (valid),
        .o_ready (o_ready),
        .i_cmd   (cmd),
        .i_data  (data),
        .i_len   (len),
        .o_csb   (o_csb),
        .o_sclk  (o_sclk),
        .o_mosi  (o_mosi),
        .o_busy  (o_busy),
        .o_done  (o_done)
`ifdef REG_SPI_SEQ_VSYNC_GATE_EN
        ,
        .i_vsync (vsync)
`endif
    );

    always #5 clk = ~clk;

`ifdef REG_SPI_SEQ_VSYNC_GATE_EN
    initial begin
        vsync = 1'b1;
        #400;
        forever begin
            vsync = 1'b0;
            #300;
            vsync = 1'b1;
            #300;
        end
    end
`endif

    typedef struct {
        logic [31:0] bits;
        int          n;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Call at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [3:0] c, input logic [23:0] d, input logic [4:0] l,
                        input int n, input logic [31:0] bits, input bit push, input bit keep);
        int waited = 0;
        cmd   = c;
        data  = d;
        len   = l;
        valid = 1'b1;
        while (!o_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) begin
            fail("accept_timeout");
            valid = 1'b0;
            return;
        end
        if (push) sb_q.push_back('{bits: bits, n: n});
        @(negedge clk);
        if (!keep) valid = 1'b0;
`ifndef REG_SPI_SEQ_VSYNC_GATE_EN
        check("accept_to_csb_low", o_csb, 0);
`endif
        check("busy_after_accept", o_busy, 1);
        check("ready_after_accept", o_ready, 0);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((sb_q.size() != 0 || !o_ready) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0 || !o_ready) fail("idle_timeout");
    endtask

    // Monitor state
    logic        prev_csb = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    bit          in_frame = 0, stable_ok = 1, gap_valid = 0, rdy_track = 0;
    int          low_cnt = 0, nb = 0, hi_cnt = 0, since = 0;
    int          stray_done = 0, idle_mosi_err = 0;
    logic [31:0] got_bits = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (in_frame) begin
                check("csb_on_reset", o_csb, 1);
                check("no_done_on_reset", o_done, 0);
            end
            in_frame  = 0;
            gap_valid = 0;
            rdy_track = 0;
        end else if (!o_csb) begin
            if (prev_csb) begin
                if (gap_valid) check("gap_ge_min", 32'(hi_cnt >= int'(GAP_CYC)), 1);
                in_frame  = 1;
                low_cnt   = 0;
                nb        = 0;
                got_bits  = '0;
                stable_ok = 1;
            end
            low_cnt++;
            if (!prev_sclk && o_sclk) begin
                got_bits = {got_bits[30:0], o_mosi};
                nb++;
            end
            if (prev_sclk && o_sclk && (o_mosi !== prev_mosi)) stable_ok = 0;
            if (o_done) stray_done++;
        end else begin
            if (o_mosi !== 1'b0) idle_mosi_err++;
            if (!prev_csb && in_frame) begin
                exp_t e;
                in_frame = 0;
                hi_cnt   = 1;
                check("done_at_csb_rise", o_done, 1);
                if (sb_q.size() == 0) begin
                    fail("unexpected_frame");
                end else begin
                    e = sb_q.pop_front();
                    check("bit_count", nb, e.n);
                    check("frame_bits", got_bits, e.bits);
                    check("csb_low_cycles", low_cnt, CLK_DIV * (2 * e.n + 2));
                    check("mosi_stable_sclk_hi", stable_ok, 1);
                end
                gap_valid = 1;
                rdy_track = 1;
                since     = 0;
            end else begin
                hi_cnt++;
                if (o_done) stray_done++;
            end
            if (rdy_track && o_ready) begin
                check("ready_after_gap", since, GAP_CYC);
                rdy_track = 0;
            end
            since++;
        end
        prev_csb  = o_csb;
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
    end

    initial begin
        int rises;
        logic ps;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_csb", o_csb, 1);
        check("rst_sclk", o_sclk, 0);
        check("rst_mosi", o_mosi, 0);
        check("rst_ready", o_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);

        send(4'hA, 24'h0000C3, 5'd8, 12, 32'hAC3, 1, 0);
        wait_idle();
        send(4'h5, 24'h123456, 5'd0, 4, 32'h5, 1, 0);
        wait_idle();
        send(4'h5, 24'hFFFFFF, 5'd31, 28, 32'h5FFFFFF, 1, 0);
        wait_idle();

        // Back-to-back with i_valid held across requests
        send(4'h3, 24'hFFF0A5, 5'd12, 16, 32'h30A5, 1, 1);
        send(4'hC, 24'h123456, 5'd24, 28, 32'hC123456, 1, 1);
        send(4'h1, 24'h000001, 5'd1, 5, 32'h03, 1, 0);
        wait_idle();

        // Abort after the 5th rising SCLK edge; this frame is never expected
        send(4'hF, 24'h00FFFF, 5'd16, 20, 32'h0, 0, 0);
        rises = 0;
        ps    = o_sclk;
        for (int i = 0; i < 2000 && rises < 5; i++) begin
            @(negedge clk);
            if (o_sclk && !ps) rises++;
            ps = o_sclk;
        end
        if (rises < 5) fail("abort_rise_wait");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_csb", o_csb, 1);
        check("abort_sclk", o_sclk, 0);
        check("abort_mosi", o_mosi, 0);
        check("abort_done", o_done, 0);
        check("abort_busy", o_busy, 0);
        check("abort_ready", o_ready, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        send(4'h6, 24'h000002, 5'd2, 6, 32'h1A, 1, 0);
        wait_idle();

        repeat (5) @(negedge clk);
        check("stray_done_pulses", stray_done, 0);
        check("mosi_nonzero_csb_high", idle_mosi_err, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
